lock_supervisor: RTL and testbench

- Sits directly downstream of the serial 010 code-lock FSM and consumes its `openlock` / `alarm` output pulses.
- Turns a successful code into a timed door-release window.
- Counts failed attempts; after `MAX_FAILS` failures it enforces a timed lockout with the buzzer on.
- Drives `lock_hold`, which is OR'd into the lock FSM's reset so the lock stays in its start state while the door is open or the system is locked out.

---
 rtl/lock_pkg.sv | 21 ++
 rtl/cycle_timer.sv | 28 ++
 rtl/lock_supervisor.sv | 117 +++++++++++
 tb/tb_lock_supervisor.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the serial code lock and its supervisor:
// state encodings and the failure-counter width.
package lock_pkg;

    localparam int FAIL_W = 4;

    // Supervisor states; 2'b11 is unused and recovers to ST_ARMED.
    typedef enum logic [1:0] {
        ST_ARMED   = 2'b00,
        ST_UNLOCK  = 2'b01,
        ST_LOCKOUT = 2'b10
    } sup_state_t;

    // States of the upstream serial 010 code-lock FSM.
    typedef enum logic [1:0] {
        LK_START = 2'b00,
        LK_GOT0  = 2'b01,
        LK_GOT01 = 2'b10
    } lock_state_t;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter with a zero flag. It is shared by the door-release
// window and the lockout period.
module cycle_timer #(
    parameter int TMR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lock_supervisor.sv
// Turns code-lock openlock/alarm pulses into a timed door-release window
// or a timed buzzer lockout after repeated failures.
module lock_supervisor
    import lock_pkg::*;
#(
    parameter int MAX_FAILS      = 3,
    parameter int UNLOCK_CYCLES  = 8,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int TMR_W          = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              openlock,
    input  logic              alarm,
    output logic              door_open,
    output logic              lockout,
    output logic              buzzer,
    output logic              lock_hold,
    output logic [FAIL_W-1:0] fail_count
);

    sup_state_t       state;
    logic             final_fail;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_en;
    logic             tmr_zero;

    assign final_fail = ((fail_count + FAIL_W'(1)) == FAIL_W'(MAX_FAILS));

    // Alarm has priority over openlock, so a simultaneous pair counts as a failure.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (state == ST_ARMED) begin
            if (alarm && final_fail) begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(LOCKOUT_CYCLES - 1);
            end else if (openlock && !alarm) begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(UNLOCK_CYCLES - 1);
            end
        end
    end

    assign tmr_en = (state == ST_UNLOCK) || (state == ST_LOCKOUT);

    cycle_timer #(
        .TMR_W(TMR_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .load_val(tmr_val),
        .en      (tmr_en),
        .zero    (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_ARMED;
            fail_count <= '0;
            door_open  <= 1'b0;
            lockout    <= 1'b0;
            buzzer     <= 1'b0;
            lock_hold  <= 1'b0;
        end else begin
            case (state)
                ST_ARMED: begin
                    buzzer <= 1'b0;
                    if (alarm) begin
                        if (final_fail) begin
                            state      <= ST_LOCKOUT;
                            fail_count <= '0;
                            lockout    <= 1'b1;
                            buzzer     <= 1'b1;
                            lock_hold  <= 1'b1;
                        end else begin
                            fail_count <= fail_count + FAIL_W'(1);
                            buzzer     <= 1'b1;
                        end
                    end else if (openlock) begin
                        state      <= ST_UNLOCK;
                        fail_count <= '0;
                        door_open  <= 1'b1;
                        lock_hold  <= 1'b1;
                    end
                end
                ST_UNLOCK: begin
                    if (tmr_zero) begin
                        state     <= ST_ARMED;
                        door_open <= 1'b0;
                        lock_hold <= 1'b0;
                    end
                end
                ST_LOCKOUT: begin
                    if (tmr_zero) begin
                        state      <= ST_ARMED;
                        fail_count <= '0;
                        lockout    <= 1'b0;
                        buzzer     <= 1'b0;
                        lock_hold  <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_ARMED;
                    fail_count <= '0;
                    door_open  <= 1'b0;
                    lockout    <= 1'b0;
                    buzzer     <= 1'b0;
                    lock_hold  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_supervisor.sv
// Directed scoreboard bench: a default-parameter instance and a minimum-parameter
// instance, with expected output vectors queued as each cycle is driven.
module tb_lock_supervisor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       openlock = 1'b0;
    logic       alarm = 1'b0;
    logic       openlock_m = 1'b0;
    logic       alarm_m = 1'b0;

    logic       door_open, lockout, buzzer, lock_hold;
    logic [3:0] fail_count;
    logic       door_open_m, lockout_m, buzzer_m, lock_hold_m;
    logic [3:0] fail_count_m;

    // Packed view: {door_open, lockout, buzzer, lock_hold, fail_count}
    localparam logic [7:0] IDLE = 8'b0000_0000;
    localparam logic [7:0] UNL  = 8'b1001_0000;
    localparam logic [7:0] LCK  = 8'b0111_0000;

    logic [7:0] exp_q[$];
    logic [7:0] exp_m_q[$];
    int checks = 0;
    int errors = 0;
    int cyc_no = 0;

    always #5 clk = ~clk;

    lock_supervisor dut (
        .clk       (clk),
        .reset     (reset),
        .openlock  (openlock),
        .alarm     (alarm),
        .door_open (door_open),
        .lockout   (lockout),
        .buzzer    (buzzer),
        .lock_hold (lock_hold),
        .fail_count(fail_count)
    );

    lock_supervisor #(
        .MAX_FAILS     (1),
        .UNLOCK_CYCLES (1),
        .LOCKOUT_CYCLES(4),
        .TMR_W         (8)
    ) dut_min (
        .clk       (clk),
        .reset     (reset),
        .openlock  (openlock_m),
        .alarm     (alarm_m),
        .door_open (door_open_m),
        .lockout   (lockout_m),
        .buzzer    (buzzer_m),
        .lock_hold (lock_hold_m),
        .fail_count(fail_count_m)
    );

    function automatic logic [7:0] fa(input logic buz, input logic [3:0] fc);
        return {3'b000, buz, 1'b0, fc} << 0 | {2'b00, buz, 1'b0, fc};
    endfunction

    // Scoreboard: one expected vector per driven cycle, compared just after the edge.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                assert ({door_open, lockout, buzzer, lock_hold, fail_count} === e)
                else begin
                    errors++;
                    $error("FAIL main c%0d: observed=%b expected=%b", cyc_no,
                           {door_open, lockout, buzzer, lock_hold, fail_count}, e);
                end
            end
            if (exp_m_q.size() > 0) begin
                e = exp_m_q.pop_front();
                checks++;
                assert ({door_open_m, lockout_m, buzzer_m, lock_hold_m, fail_count_m} === e)
                else begin
                    errors++;
                    $error("FAIL min c%0d: observed=%b expected=%b", cyc_no,
                           {door_open_m, lockout_m, buzzer_m, lock_hold_m, fail_count_m}, e);
                end
            end
            cyc_no++;
        end
    end

    task automatic cyc(input logic r, input logic o, input logic a,
                       input logic om, input logic am,
                       input logic [7:0] e, input logic [7:0] em);
        @(negedge clk);
        reset      = r;
        openlock   = o;
        alarm      = a;
        openlock_m = om;
        alarm_m    = am;
        exp_q.push_back(e);
        exp_m_q.push_back(em);
    endtask

    task automatic idle_n(input int n, input logic [7:0] e, input logic [7:0] em);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e, em);
    endtask

    initial begin
        // Reset state
        cyc(1, 0, 0, 0, 0, IDLE, IDLE);
        cyc(1, 0, 0, 0, 0, IDLE, IDLE);

        // Successful code: door held exactly 8 cycles
        cyc(0, 1, 0, 0, 0, UNL, IDLE);
        idle_n(7, UNL, IDLE);
        idle_n(2, IDLE, IDLE);

        // Reset in the middle of the release window
        cyc(0, 1, 0, 0, 0, UNL, IDLE);
        idle_n(3, UNL, IDLE);
        cyc(1, 0, 0, 0, 0, IDLE, IDLE);
        idle_n(2, IDLE, IDLE);

        // Two failures then a success
        cyc(0, 0, 1, 0, 0, fa(1'b1, 4'd1), IDLE);
        cyc(0, 0, 0, 0, 0, fa(1'b0, 4'd1), IDLE);
        cyc(0, 0, 1, 0, 0, fa(1'b1, 4'd2), IDLE);
        cyc(0, 0, 0, 0, 0, fa(1'b0, 4'd2), IDLE);
        cyc(0, 1, 0, 0, 0, UNL, IDLE);
        idle_n(7, UNL, IDLE);
        cyc(0, 0, 0, 0, 0, IDLE, IDLE);

        // Back-to-back alarms into a 16-cycle lockout that ignores inputs
        cyc(0, 0, 1, 0, 0, fa(1'b1, 4'd1), IDLE);
        cyc(0, 0, 1, 0, 0, fa(1'b1, 4'd2), IDLE);
        cyc(0, 0, 1, 0, 0, LCK, IDLE);
        idle_n(4, LCK, IDLE);
        cyc(0, 1, 0, 0, 0, LCK, IDLE);
        cyc(0, 0, 1, 0, 0, LCK, IDLE);
        idle_n(9, LCK, IDLE);
        idle_n(2, IDLE, IDLE);

        // Simultaneous openlock+alarm counts as a failure, including the final one
        cyc(0, 1, 1, 0, 0, fa(1'b1, 4'd1), IDLE);
        cyc(0, 0, 0, 0, 0, fa(1'b0, 4'd1), IDLE);
        cyc(0, 0, 1, 0, 0, fa(1'b1, 4'd2), IDLE);
        cyc(0, 1, 1, 0, 0, LCK, IDLE);
        idle_n(15, LCK, IDLE);
        cyc(0, 0, 0, 0, 0, IDLE, IDLE);

        // Minimum parameters: first alarm locks out, openlock gives a 1-cycle release
        cyc(0, 0, 0, 0, 1, IDLE, LCK);
        idle_n(3, IDLE, LCK);
        cyc(0, 0, 0, 0, 0, IDLE, IDLE);
        cyc(0, 0, 0, 1, 0, IDLE, UNL);
        cyc(0, 0, 0, 0, 0, IDLE, IDLE);
        cyc(0, 0, 0, 1, 1, IDLE, LCK);
        idle_n(3, IDLE, LCK);
        idle_n(2, IDLE, IDLE);

        @(posedge clk);
        #3;
        checks++;
        assert ((exp_q.size() + exp_m_q.size()) == 0)
        else begin
            errors++;
            $error("FAIL drain: observed=%0d expected=0 pending entries",
                   exp_q.size() + exp_m_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
